int2f_seq: RTL and testbench
============================

Name: int2f_seq

Overview:
- Sequential signed/unsigned 32-bit integer to IEEE-754 single-precision converter.
- Sits directly upstream of the combinational float adder and produces its a/b operands in the same packed format: sign[31], exp[30:23], mant[22:0].
- Normalizes iteratively, one left shift per cycle, using a leading-zero walk.
- Truncates (round toward zero) to match the adder's truncating arithmetic.
- valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
- SIGNED, 1: 1 = input is two's-complement signed; 0 = input is unsigned.
- BIAS, 127: exponent bias.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept (high only in IDLE)
- in_data  input  32  integer operand
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  consumer accepts out_data
- out_data  output  32  packed single-precision result
- busy  output  1  high in NORM or DONE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; out_valid = 0; out_data = 0; busy = 0; internal mag = 0, cnt = 0, sign = 0.
  - Reset takes effect immediately in any state, including mid-NORM. An in-flight conversion is discarded and no partial result is ever presented.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready (call this cycle T), capture the operand:
    - SIGNED=1: sign = in_data[31]; mag = |in_data| as unsigned 32 bits. -2^31 gives mag = 0x80000000, which is legal.
    - SIGNED=0: sign = 0; mag = in_data.
    - cnt = 0.
  - If mag == 0, go to DONE with out_data = 0x00000000 (sign forced 0, so there is no negative zero). out_valid is high at T+1.
  - Otherwise go to NORM.
- State NORM (one evaluation per cycle):
  - If mag[31] == 1: register out_data = {sign, BIAS+31-cnt (8 bits), mag[30:8]} and go to DONE.
  - Else: mag <= mag << 1; cnt <= cnt + 1; stay in NORM.
  - cnt is 5 bits and never exceeds 31 (mag is nonzero), so the exponent range is 127..158 with no over- or underflow.
  - mag[7:0] is dropped (truncation, no rounding, no sticky bit).
- Latency:
  - out_valid rises at T + 2 + lz, where lz is the leading-zero count of mag.
  - Zero input: T+1.
  - Range: 2 cycles (|x| >= 2^31) to 33 cycles (|x| = 1).
- State DONE:
  - out_valid = 1 and out_data is stable; in_ready = 0.
  - On out_ready go to IDLE: out_valid drops and in_ready rises on the next cycle. This gives at least one cycle between the output handshake and the next input accept; accepting an input in the same cycle as the output handshake is not allowed.
  - If out_ready stays low, hold indefinitely (backpressure); out_data must not change.
- Other rules:
  - in_valid while not in IDLE is ignored, and in_data need not be held.
  - out_data keeps its last value after the handshake; it is only meaningful while out_valid is high.
  - Every output comes straight from a register or from state decode. There is no combinational path from in_* to out_*.

Decomposition:
- Shared package fp_pkg holds:
  - FP_W=32, EXP_W=8, MANT_W=23, FP_BIAS=127;
  - the packed-field positions;
  - the converter state enum {IDLE, NORM, DONE}.
- The future float-to-int and multiplier stages reuse this package.
- No sub-module. Normalization is a single shift-register step and stays inline.

Test Plan:
- in_data=1 -> out_data=0x3F800000, out_valid at T+33; in_data=-1 -> 0xBF800000 at T+33.
- in_data=0 -> 0x00000000 at T+1; in_data=0x80000000 (SIGNED=1) -> 0xCF000000 at T+2.
- in_data=0x7FFFFFFF -> 0x4EFFFFFF (truncated); in_data=0x01000001 -> 0x4B800000 (low bit lost).
- SIGNED=0, in_data=0xFFFFFFFF -> 0x4F7FFFFF at T+2.
- Backpressure: hold out_ready low 10 cycles after out_valid -> out_data and out_valid stable, in_ready=0, extra in_valid pulses ignored. Then pulse out_ready -> IDLE next cycle and the next operand (5 -> 0x40A00000) converts correctly.
- Reset mid-op: assert rst_n low during NORM of in_data=1 -> out_valid=0 and out_data=0 immediately. After release, in_data=3 -> 0x40400000 with no stale result output.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision field layout and converter state encoding.
// Also used by the float-to-int and multiplier stages.
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int FP_BIAS  = 127;

    localparam int SIGN_POS = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } conv_state_t;

    function automatic logic [FP_W-1:0] pack_fp(input logic s,
                                                input logic [EXP_W-1:0] e,
                                                input logic [MANT_W-1:0] m);
        logic [FP_W-1:0] r;
        r = '0;
        r[SIGN_POS]        = s;
        r[EXP_MSB:EXP_LSB] = e;
        r[MANT_MSB:0]      = m;
        return r;
    endfunction

endpackage

// File: rtl/int2f_seq.sv
// Sequential 32-bit integer to single-precision converter, one normalizing
// shift per cycle, truncating toward zero to match the downstream adder.
module int2f_seq
    import fp_pkg::*;
#(
    parameter int SIGNED = 1,
    parameter int BIAS   = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    conv_state_t       state;
    conv_state_t       next_state;
    logic [FP_W-1:0]   mag;
    logic [FP_W-1:0]   cap_mag;
    logic              cap_sign;
    logic [4:0]        cnt;
    logic              sign;
    logic [EXP_W-1:0]  exp_field;

    // The most negative input negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        cap_sign = 1'b0;
        cap_mag  = in_data;
        if (SIGNED != 0 && in_data[FP_W-1]) begin
            cap_sign = 1'b1;
            cap_mag  = ~in_data + 32'd1;
        end
    end

    assign exp_field = EXP_W'(BIAS + 31) - EXP_W'(cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = (cap_mag == '0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag[FP_W-1]) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Bits below the 23 kept mantissa bits are simply dropped once the leading one reaches bit 31.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= cap_sign;
                        mag  <= cap_mag;
                        cnt  <= '0;
                        if (cap_mag == '0) begin
                            out_data <= '0;
                        end
                    end
                end
                NORM: begin
                    if (mag[FP_W-1]) begin
                        out_data <= pack_fp(sign, exp_field, mag[FP_W-2 -: MANT_W]);
                    end else begin
                        mag <= mag << 1;
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int2f_seq.sv
// Scoreboard bench for int2f_seq: a signed and an unsigned instance checked
// for result value, latency, backpressure and asynchronous reset behaviour.
module tb_int2f_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
    logic [31:0] in_data_s, out_data_s;
    logic        in_valid_u, in_ready_u, out_valid_u, out_ready_u, busy_u;
    logic [31:0] in_data_u, out_data_u;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data_q[$];
    int          exp_lat_q[$];

    always #5 clk = ~clk;

    int2f_seq #(.SIGNED(1), .BIAS(127)) u_signed (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
        .busy(busy_s)
    );

    int2f_seq #(.SIGNED(0), .BIAS(127)) u_unsigned (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_u), .in_ready(in_ready_u), .in_data(in_data_u),
        .out_valid(out_valid_u), .out_ready(out_ready_u), .out_data(out_data_u),
        .busy(busy_u)
    );

    // Reference conversion: locate the most significant set bit, then align it.
    function automatic logic [31:0] model_data(input logic [31:0] x, input bit is_signed);
        logic [31:0] m;
        logic [31:0] n;
        logic        s;
        int          p;
        s = is_signed && x[31];
        m = s ? (~x + 32'd1) : x;
        if (m == 32'd0) return 32'd0;
        p = 31;
        while (!m[p]) p--;
        n = m << (31 - p);
        return {s, 8'(127 + p), n[30:8]};
    endfunction

    function automatic int model_lat(input logic [31:0] x, input bit is_signed);
        logic [31:0] m;
        int          p;
        m = (is_signed && x[31]) ? (~x + 32'd1) : x;
        if (m == 32'd0) return 1;
        p = 31;
        while (!m[p]) p--;
        return 33 - p;
    endfunction

    // Leaves the bench at the falling edge of the first cycle after the accept edge.
    task automatic drive_in(input bit uns, input logic [31:0] din, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!(uns ? in_ready_u : in_ready_s) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            ok = 1'b0;
            return;
        end
        if (uns) begin
            in_valid_u = 1'b1;
            in_data_u  = din;
        end else begin
            in_valid_s = 1'b1;
            in_data_s  = din;
        end
        @(negedge clk);
        in_valid_u = 1'b0;
        in_valid_s = 1'b0;
        in_data_u  = $urandom;
        in_data_s  = $urandom;
    endtask

    task automatic wait_out(input bit uns, output logic [31:0] data, output int lat, output bit ok);
        lat = 1;
        while (!(uns ? out_valid_u : out_valid_s) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok   = uns ? out_valid_u : out_valid_s;
        data = uns ? out_data_u : out_data_s;
    endtask

    task automatic release_out(input bit uns);
        if (uns) out_ready_u = 1'b1;
        else     out_ready_s = 1'b1;
        @(negedge clk);
        out_ready_u = 1'b0;
        out_ready_s = 1'b0;
    endtask

    task automatic convert(input bit uns, input logic [31:0] din,
                           output logic [31:0] data, output int lat, output bit ok);
        bit ok_in;
        drive_in(uns, din, ok_in);
        wait_out(uns, data, lat, ok);
        ok = ok && ok_in;
        release_out(uns);
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid_s !== 1'b0 || out_data_s !== 32'd0 || busy_s !== 1'b0 || in_ready_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_signed: got v=%b d=%h busy=%b rdy=%b expected v=0 d=00000000 busy=0 rdy=1",
                     out_valid_s, out_data_s, busy_s, in_ready_s);
        end
        checks++;
        if (out_valid_u !== 1'b0 || out_data_u !== 32'd0 || busy_u !== 1'b0 || in_ready_u !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_unsigned: got v=%b d=%h busy=%b rdy=%b expected v=0 d=00000000 busy=0 rdy=1",
                     out_valid_u, out_data_u, busy_u, in_ready_u);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_signed_table();
        logic [31:0] din[6];
        logic [31:0] ed[6];
        int          el[6];
        logic [31:0] got, e;
        int          lat, l;
        bit          ok;
        din = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h01000001};
        ed  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000, 32'h4EFFFFFF, 32'h4B800000};
        el  = '{33, 33, 1, 2, 3, 9};
        for (int i = 0; i < 6; i++) begin
            exp_data_q.push_back(ed[i]);
            exp_lat_q.push_back(el[i]);
            convert(1'b0, din[i], got, lat, ok);
            e = exp_data_q.pop_front();
            l = exp_lat_q.pop_front();
            checks++;
            if (!ok || got !== e) begin
                errors++;
                $display("[TB] FAIL signed_data[%0h]: got %h (valid=%b) expected %h", din[i], got, ok, e);
            end
            checks++;
            if (lat !== l) begin
                errors++;
                $display("[TB] FAIL signed_latency[%0h]: got %0d expected %0d", din[i], lat, l);
            end
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] din[4];
        logic [31:0] ed[4];
        int          el[4];
        logic [31:0] got, e;
        int          lat, l;
        bit          ok;
        din = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h00000000};
        ed  = '{32'h4F7FFFFF, 32'h4F000000, 32'h3F800000, 32'h00000000};
        el  = '{2, 2, 33, 1};
        for (int i = 0; i < 4; i++) begin
            exp_data_q.push_back(ed[i]);
            exp_lat_q.push_back(el[i]);
            convert(1'b1, din[i], got, lat, ok);
            e = exp_data_q.pop_front();
            l = exp_lat_q.pop_front();
            checks++;
            if (!ok || got !== e) begin
                errors++;
                $display("[TB] FAIL unsigned_data[%0h]: got %h (valid=%b) expected %h", din[i], got, ok, e);
            end
            checks++;
            if (lat !== l) begin
                errors++;
                $display("[TB] FAIL unsigned_latency[%0h]: got %0d expected %0d", din[i], lat, l);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] din[8];
        logic [31:0] got[8];
        int          lat[8];
        bit          ok[8];
        bit          uns[8];
        logic [31:0] e;
        int          l;
        for (int i = 0; i < 8; i++) begin
            din[i] = $urandom >> $urandom_range(0, 31);
            if ((i % 2) == 0) din[i] = ~din[i] + 32'd1;
            uns[i] = (i >= 6);
            exp_data_q.push_back(model_data(din[i], !uns[i]));
            exp_lat_q.push_back(model_lat(din[i], !uns[i]));
        end
        for (int i = 0; i < 8; i++) begin
            convert(uns[i], din[i], got[i], lat[i], ok[i]);
        end
        for (int i = 0; i < 8; i++) begin
            e = exp_data_q.pop_front();
            l = exp_lat_q.pop_front();
            checks++;
            if (!ok[i] || got[i] !== e) begin
                errors++;
                $display("[TB] FAIL b2b_data[%0h]: got %h (valid=%b) expected %h", din[i], got[i], ok[i], e);
            end
            checks++;
            if (lat[i] !== l) begin
                errors++;
                $display("[TB] FAIL b2b_latency[%0h]: got %0d expected %0d", din[i], lat[i], l);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got, e;
        int          lat, l;
        bit          ok, ok_in, stable;
        exp_data_q.push_back(model_data(32'h12345678, 1'b1));
        drive_in(1'b0, 32'h12345678, ok_in);
        wait_out(1'b0, got, lat, ok);
        e = exp_data_q.pop_front();
        checks++;
        if (!ok || !ok_in || got !== e) begin
            errors++;
            $display("[TB] FAIL bp_data: got %h (valid=%b) expected %h", got, ok, e);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid_s = 1'b1;
            in_data_s  = $urandom;
            @(negedge clk);
            if (out_valid_s !== 1'b1 || out_data_s !== e || in_ready_s !== 1'b0) stable = 1'b0;
        end
        in_valid_s = 1'b0;
        checks++;
        if (!stable) begin
            errors++;
            $display("[TB] FAIL bp_hold: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=0",
                     out_valid_s, out_data_s, in_ready_s, e);
        end
        release_out(1'b0);
        checks++;
        if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0 || busy_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_to_idle: got rdy=%b v=%b busy=%b expected rdy=1 v=0 busy=0",
                     in_ready_s, out_valid_s, busy_s);
        end
        exp_data_q.push_back(32'h40A00000);
        exp_lat_q.push_back(31);
        convert(1'b0, 32'd5, got, lat, ok);
        e = exp_data_q.pop_front();
        l = exp_lat_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("[TB] FAIL bp_next_data: got %h (valid=%b) expected %h", got, ok, e);
        end
        checks++;
        if (lat !== l) begin
            errors++;
            $display("[TB] FAIL bp_next_latency: got %0d expected %0d", lat, l);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, e;
        int          lat, l;
        bit          ok, ok_in, stray;
        drive_in(1'b0, 32'd1, ok_in);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok_in || busy_s !== 1'b1 || out_valid_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_norm_busy: got busy=%b v=%b expected busy=1 v=0", busy_s, out_valid_s);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_s !== 1'b0 || out_data_s !== 32'd0 || busy_s !== 1'b0 || in_ready_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b d=%h busy=%b rdy=%b expected v=0 d=00000000 busy=0 rdy=1",
                     out_valid_s, out_data_s, busy_s, in_ready_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_s !== 1'b0 || busy_s !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("[TB] FAIL mid_reset_stale: got stray valid/busy expected none");
        end
        exp_data_q.push_back(32'h40400000);
        exp_lat_q.push_back(32);
        convert(1'b0, 32'd3, got, lat, ok);
        e = exp_data_q.pop_front();
        l = exp_lat_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("[TB] FAIL after_reset_data: got %h (valid=%b) expected %h", got, ok, e);
        end
        checks++;
        if (lat !== l) begin
            errors++;
            $display("[TB] FAIL after_reset_latency: got %0d expected %0d", lat, l);
        end
    endtask

    initial begin
        in_valid_s  = 1'b0;
        in_valid_u  = 1'b0;
        in_data_s   = '0;
        in_data_u   = '0;
        out_ready_s = 1'b0;
        out_ready_u = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] starting int2f_seq tests");
        test_reset();
        test_signed_table();
        test_unsigned();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
